// File: rtl/up_counter_tcell.sv
// Synchronous T flip-flop: one bit of the up counter.
//
// Ports:
//   t    toggle enable; when high at a rising clk edge the stored bit inverts
//   clk  clock; all updates on its rising edge
//   rst  synchronous active-low reset (0 = clear), sampled on rising clk
//   q    stored bit, driven straight from the register
module up_counter_tcell (
  input  logic t,
  input  logic clk,
  input  logic rst,
  output logic q
);

  logic q_q;

  // Reset takes priority over toggling; no asynchronous path.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= 1'b0;
    end else if (t) begin
      q_q <= ~q_q;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/up_counter.sv
// Free-running n-bit synchronous binary up counter, wrapping modulo 2**n.
//
// Built from n T flip-flop cells sharing one clock. Bit i toggles when all
// lower bits are 1, which yields q+1 with the carry-out discarded.
//
// Parameters:
//   n    counter width in bits, 1..32
// Ports:
//   clk  clock; the count advances on every rising edge
//   rst  synchronous active-low reset (0 = clear to zero), sampled on rising clk
//   q    current count, driven directly from the cell registers
module up_counter #(
  parameter int unsigned n = 4
) (
  input  logic         clk,
  input  logic         rst,
  output logic [n-1:0] q
);

  logic [n-1:0] t;

  // AND carry chain: t[0] = 1, t[i] = t[i-1] & q[i-1]. A running carry is used
  // so the block never reads back its own output vector.
  always_comb begin
    logic carry;
    t     = '0;
    carry = 1'b1;
    for (int unsigned i = 0; i < n; i++) begin
      t[i]  = carry;
      carry = carry & q[i];
    end
  end

  for (genvar i = 0; i < n; i++) begin : g_cell
    up_counter_tcell u_cell (
      .t   (t[i]),
      .clk (clk),
      .rst (rst),
      .q   (q[i])
    );
  end

endmodule

// File: tb/tb_up_counter.sv
// Directed self-checking bench for up_counter at widths 1, 4 and 8.
// All three instances share clk and rst; per-width reference models advance
// on every rising edge alongside hand-computed expectations for n=4.
module tb_up_counter;

  logic       clk;
  logic       rst;
  logic [3:0] q4;
  logic [0:0] q1;
  logic [7:0] q8;

  // Reference models: next = rst ? (cur + 1) mod 2**n : 0
  logic [3:0] m4;
  logic [0:0] m1;
  logic [7:0] m8;

  int n_checks = 0;
  int n_pass   = 0;

  up_counter #(.n(4)) u_dut4 (.clk(clk), .rst(rst), .q(q4));
  up_counter #(.n(1)) u_dut1 (.clk(clk), .rst(rst), .q(q1));
  up_counter #(.n(8)) u_dut8 (.clk(clk), .rst(rst), .q(q8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, update the models from rst sampled at that edge,
  // then compare every instance 1 time unit later.
  task automatic step();
    logic r;
    @(posedge clk);
    r = rst;
    m4 = r ? m4 + 4'd1 : 4'd0;
    m1 = r ? m1 + 1'b1 : 1'b0;
    m8 = r ? m8 + 8'd1 : 8'd0;
    #1;
    check("model_n4", 32'(q4), 32'(m4));
    check("model_n1", 32'(q1), 32'(m1));
    check("model_n8", 32'(q8), 32'(m8));
  endtask

  initial begin
    m4  = 'x;
    m1  = 'x;
    m8  = 'x;
    rst = 1'b0;

    // Reset held for two edges.
    step();
    check("reset_edge1", 32'(q4), 32'd0);
    step();
    check("reset_edge2", 32'(q4), 32'd0);
    check("reset_n8", 32'(q8), 32'd0);

    // Count 1..15 out of reset.
    #4 rst = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      step();
      check("count", 32'(q4), 32'(i));
    end

    // Wrap 15 -> 0 -> 1.
    step();
    check("wrap_to_0", 32'(q4), 32'd0);
    step();
    check("wrap_then_1", 32'(q4), 32'd1);

    // Advance to 9, then assert reset midway between edges.
    for (int i = 2; i <= 9; i++) step();
    check("at_9", 32'(q4), 32'd9);
    #4 rst = 1'b0;
    #1 check("mid_reset_hold", 32'(q4), 32'd9);
    step();
    check("mid_reset_clear", 32'(q4), 32'd0);
    #4 rst = 1'b1;
    step();
    check("resume_1", 32'(q4), 32'd1);
    step();
    check("resume_2", 32'(q4), 32'd2);

    // Reset pulse entirely between edges has no effect.
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    step();
    check("glitch_ignored", 32'(q4), 32'd3);

    // n=1 toggling and n=8 wrap after 256 edges out of reset.
    #4 rst = 1'b0;
    step();
    check("n1_reset", 32'(q1), 32'd0);
    check("n8_reset", 32'(q8), 32'd0);
    #4 rst = 1'b1;
    step();
    check("n1_toggle_1", 32'(q1), 32'd1);
    step();
    check("n1_toggle_0", 32'(q1), 32'd0);
    step();
    check("n1_toggle_1b", 32'(q1), 32'd1);
    for (int i = 4; i <= 255; i++) step();
    check("n8_at_255", 32'(q8), 32'd255);
    check("n4_at_255", 32'(q4), 32'd15);
    step();
    check("n8_wrap_0", 32'(q8), 32'd0);
    check("n4_wrap_0", 32'(q4), 32'd0);
    step();
    check("n8_after_wrap", 32'(q8), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
